// File: rtl/sqr_share_arb.sv
// sqr_share_arb: round-robin arbiter plus two-stage pipeline that shares one signed
// squarer (SqrSgn) between nreq requesters.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  [nreq]        per-requester operand valid
//   req_x_i      [nreq*width]  per-requester signed operand, requester r at [r*width +: width]
//   req_ready_o  [nreq]        one-hot (or zero) accept strobe
//   rsp_valid_o               result register holds a product
//   rsp_ready_i               consumer takes the product this cycle
//   rsp_p_o      [2*width]     signed square of the issued operand
//   rsp_id_o     [idw]         index of the issuing requester
//   busy_o                    either pipeline stage holds an operand
//
// SqrSgn: combinational full-precision signed squarer.
//   X [width]    signed operand
//   P [2*width]  signed X*X (never negative, never overflows)

module SqrSgn #(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic [width-1:0]   X,
  output logic [2*width-1:0] P
);

  if (speed == 0) begin : g_shift_add
    // Square the magnitude; -2^(width-1) maps to 2^(width-1), which still fits unsigned.
    logic [width-1:0]   mag;
    logic [2*width-1:0] acc;

    always_comb begin
      mag = X[width-1] ? (~X + 1'b1) : X;
      acc = '0;
      for (int i = 0; i < width; i++) begin
        if (mag[i]) begin
          acc = acc + ({{width{1'b0}}, mag} << i);
        end
      end
    end

    assign P = acc;
  end else begin : g_mult
    logic signed [2*width-1:0] xe;

    assign xe = {{width{X[width-1]}}, X};
    assign P  = xe * xe;
  end

endmodule

module sqr_share_arb #(
  parameter int width = 8,
  parameter int speed = 0,
  parameter int nreq  = 4,
  parameter int idw   = $clog2(nreq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [nreq-1:0]         req_valid_i,
  input  logic [nreq*width-1:0]   req_x_i,
  output logic [nreq-1:0]         req_ready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [2*width-1:0]      rsp_p_o,
  output logic [idw-1:0]          rsp_id_o,
  output logic                    busy_o
);

  // Stage 1: operand register feeding the squarer.
  logic             v1_q, v1_d;
  logic [width-1:0] x1_q, x1_d;
  logic [idw-1:0]   id1_q, id1_d;

  // Stage 2: product register feeding the response port.
  logic               v2_q, v2_d;
  logic [2*width-1:0] p2_q, p2_d;
  logic [idw-1:0]     id2_q, id2_d;

  // Round-robin pointer: highest-priority requester.
  logic [idw-1:0] ptr_q, ptr_d;

  logic               adv1, adv2;
  logic               any_vld;
  logic [idw-1:0]     gnt_idx;
  logic               accept;
  logic [2*width-1:0] sq_p;

  assign adv2 = ~v2_q | rsp_ready_i;
  assign adv1 = ~v1_q | adv2;

  // Priority search starting at ptr_q; walking offsets high-to-low lets the smallest
  // offset win without needing a break.
  always_comb begin
    logic [idw-1:0] cand;
    any_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = nreq - 1; k >= 0; k--) begin
      cand = idw'((int'(ptr_q) + k) % nreq);
      if (req_valid_i[cand]) begin
        any_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept = any_vld & adv1;

  always_comb begin
    req_ready_o = '0;
    for (int r = 0; r < nreq; r++) begin
      req_ready_o[r] = accept & (gnt_idx == idw'(r));
    end
  end

  SqrSgn #(
    .width (width),
    .speed (speed)
  ) u_sqr (
    .X (x1_q),
    .P (sq_p)
  );

  always_comb begin
    v1_d  = v1_q;
    x1_d  = x1_q;
    id1_d = id1_q;
    ptr_d = ptr_q;
    if (adv1) begin
      if (any_vld) begin
        v1_d  = 1'b1;
        x1_d  = req_x_i[int'(gnt_idx)*width +: width];
        id1_d = gnt_idx;
        ptr_d = (gnt_idx == idw'(nreq - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        v1_d = 1'b0;
      end
    end
  end

  always_comb begin
    v2_d  = v2_q;
    p2_d  = p2_q;
    id2_d = id2_q;
    if (adv2) begin
      v2_d  = v1_q;
      p2_d  = sq_p;
      id2_d = id1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q  <= 1'b0;
      x1_q  <= '0;
      id1_q <= '0;
      v2_q  <= 1'b0;
      p2_q  <= '0;
      id2_q <= '0;
      ptr_q <= '0;
    end else begin
      v1_q  <= v1_d;
      x1_q  <= x1_d;
      id1_q <= id1_d;
      v2_q  <= v2_d;
      p2_q  <= p2_d;
      id2_q <= id2_d;
      ptr_q <= ptr_d;
    end
  end

  assign rsp_valid_o = v2_q;
  assign rsp_p_o     = p2_q;
  assign rsp_id_o    = id2_q;
  assign busy_o      = v1_q | v2_q;

endmodule

// File: doc/sqr_share_arb.md
# sqr_share_arb

Round-robin arbiter and two-stage pipeline sequencer that shares one `SqrSgn` signed squarer between `nreq` requesters. Each requester presents an operand over a valid/ready handshake. The block grants one requester per cycle and registers the operand ahead of the squarer. It registers the product and the winner's index behind the squarer and returns them on a single response port with backpressure. It sits between requester units and the combinational `SqrSgn` datapath, which it instantiates internally.

## Interface
Parameters:
- `width`, 8: operand width; `width >= 4`; passed to `SqrSgn`.
- `speed`, 0: performance parameter; passed unchanged to `SqrSgn`.
- `nreq`, 4: number of requesters; `nreq >= 2`.
- `idw`, `$clog2(nreq)`: width of the requester index.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_ni`  in  1  reset; asynchronous assertion, active-low.
- `req_valid_i`  in  `nreq`  bit r: requester r presents an operand.
- `req_x_i`  in  `nreq*width`  operand of requester r at bits `[r*width +: width]`; signed two's complement.
- `req_ready_o`  out  `nreq`  one-hot or zero; bit r: operand of requester r is accepted this cycle.
- `rsp_valid_o`  out  1  result register holds a valid product.
- `rsp_ready_i`  in  1  consumer accepts the product this cycle.
- `rsp_p_o`  out  `2*width`  signed product `X*X`.
- `rsp_id_o`  out  `idw`  index of the requester that issued the operand.
- `busy_o`  out  1  OR of the stage-1 and stage-2 valid bits.

## Operation
State:
- Stage 1 (S1) holds `v1`, `x1[width]` and `id1`. S1 drives the `X` input of a `SqrSgn #(width, speed)` instance.
- Stage 2 (S2) holds `v2`, `p2[2*width]` and `id2`. S2 drives `rsp_p_o` and `rsp_id_o`.
- The round-robin pointer `ptr[idw]` names the highest-priority requester.

Control equations:
- `adv2 = ~v2 | rsp_ready_i`: S2 can load this cycle.
- `adv1 = ~v1 | adv2`: S1 can load this cycle.
- Arbitration: search `req_valid_i` starting at `ptr` and incrementing modulo `nreq`. The first asserted index is the winner `g`.
- `req_ready_o[g] = adv1` if any request is valid; otherwise `req_ready_o = 0`.
- `req_ready_o` depends combinationally on `req_valid_i`, `v1`, `v2` and `rsp_ready_i`. It does not depend on `req_x_i`.
- Accept means `req_valid_i[g] & req_ready_o[g]`. On accept: `x1 <= req_x_i[g]`, `id1 <= g`, `v1 <= 1`, `ptr <= (g+1) mod nreq`.
- If `adv1` holds and there is no valid request: `v1 <= 0` and `ptr` is unchanged.
- If `adv1` is low: S1 and `ptr` hold.
- If `adv2` holds: `p2 <= SqrSgn.P`, `id2 <= id1`, `v2 <= v1`. Otherwise S2 holds.

Datapath and handshake rules:
- Arithmetic is the full-precision signed square; no overflow is possible. `-2^(width-1)` squares to `2^(2*width-2)`.
- A requester that is not granted keeps its operand. Its `req_valid_i` may stay high indefinitely.
- `rsp_p_o` and `rsp_id_o` are stable while `rsp_valid_o & ~rsp_ready_i`.
- Simultaneous response pop and new accept in the same cycle is legal, giving full throughput of 1 result per cycle.
- Responses return in acceptance order. There is no reordering and no drop.

Reset:
- Reset clears `v1`, `v2` and `ptr`, and zeroes `x1`, `id1`, `p2` and `id2`.
- Asserting reset mid-operation discards all in-flight operands. No response is emitted for them.

## Timing
- Reset values: `rsp_valid_o = 0`, `rsp_p_o = 0`, `rsp_id_o = 0`, `busy_o = 0`. `req_ready_o` is a function of inputs and is 0 while no request is valid.
- Latency: an accept in cycle t gives `rsp_valid_o` high in cycle t+2 if the consumer does not stall.
- Throughput: 1 product per cycle while `rsp_ready_i` is held high.
- With `rsp_ready_i` held low:
  - The pipeline fills with two entries.
  - `req_ready_o` is all zero from the cycle after the second accept.
  - It reasserts in the cycle `rsp_ready_i` rises.
- Fairness: each continuously requesting requester is granted at least once every `nreq` accepts.
- The pointer wraps from `nreq-1` to 0.
- The `SqrSgn` critical path lies between S1 and S2 only. The arbiter path is `req_valid_i` through the priority search to `req_ready_o`; it does not pass through `SqrSgn`.

## Test plan
1. After reset, with `width=8`, `nreq=4`: a single request from requester 2 with `X=8'h80`, `rsp_ready_i=1`.
   - `req_ready_o=4'b0100` in cycle 0.
   - Cycle 2: `rsp_valid_o=1`, `rsp_p_o=16'h4000`, `rsp_id_o=2`.
2. All 4 requesters valid continuously, with operands `8'hFF`, `8'h7F`, `8'h00`, `8'h81`, and `rsp_ready_i=1`.
   - Grants go 0,1,2,3,0,…
   - Responses are `16'h0001`, `16'h3F01`, `16'h0000`, `16'h3F01` with matching ids, one per cycle.
3. Backpressure: `rsp_ready_i=0` with 2 requesters valid.
   - Exactly 2 accepts occur, then `req_ready_o=0`.
   - `rsp_p_o` and `rsp_id_o` stay constant for 10 cycles.
   - After `rsp_ready_i` rises: the remaining results drain in order and arbitration resumes.
4. Exhaustive values: requester 0 only, sweep `X` over all 256 values.
   - Every `rsp_p_o` equals the signed `X*X`.
   - `ptr` rotates to 1 and stays there.
5. Reset mid-operation: assert `rst_ni=0` for 1 cycle while `v1=v2=1`.
   - `rsp_valid_o`, `busy_o` and `ptr` are 0 immediately (asynchronous).
   - No stale response appears after release.
   - The first new grant goes to the lowest valid index.
6. Intermittent requests: requester 3 requests alone, then requesters 0 and 3 request together.
   - The next grant goes to 0, because the pointer wrapped from 3 to 0.
   - Requester 3's operand is held until it is granted on the following accept.
